framebuffer_scanout: RTL and testbench
======================================

# framebuffer_scanout

Display-side reader for the double-buffered 8-bpp SDRAM framebuffer that the sprite/score blitters write. It reads the buffer *not* currently selected by `frame_flip` one 640-pixel line (40 × 128-bit words) at a time into a ping-pong line buffer, one line ahead of the VGA scan. It returns the 8-bit palette index for the current `draw_x`. It competes for SDRAM through the same `sdram_wait` / `sdram_ac` arbiter handshake as the writers.

## Interface
Parameters:
- `FB_BASE0`, 22'h100000, word address of framebuffer 0
- `FB_BASE1`, 22'h200000, word address of framebuffer 1
- `WORDS_PER_LINE`, 40, 128-bit words per line
- `LINES`, 480, active lines per frame

Ports:
- `clk`  in  1  system clock; all logic is single-clock
- `reset`  in  1  asynchronous, active-high
- `frame_flip`  in  1  buffer being drawn: 0 = `FB_BASE0`, 1 = `FB_BASE1`; scanout reads the other one
- `new_frame`  in  1  one-cycle pulse during vblank
- `line_start`  in  1  one-cycle pulse at the start of active line `line_y`
- `line_y`  in  10  line now being displayed, 0..`LINES`-1
- `draw_x`  in  10  pixel column, 0..639
- `sdram_wait`  in  1  arbiter busy; no new request may be raised
- `sdram_ac`  in  1  request accepted this cycle
- `sdram_rdvalid`  in  1  `sdram_rdata` valid this cycle
- `sdram_rdata`  in  128  read word; byte k = bits [8k+7:8k] = pixel 16·w+k
- `sdram_rd`  out  1  read request
- `sdram_addr`  out  22  read word address
- `pixel`  out  8  palette index for `draw_x`
- `busy`  out  1  a line fetch is in progress
- `underrun`  out  1  sticky flag; cleared only by reset

## Operation
- **On `new_frame`:**
  - Latch `disp_base` = `frame_flip` ? `FB_BASE0` : `FB_BASE1`.
  - Fetch line 0 into half 0.
- **On `line_start`:**
  - Display half = `line_y[0]`.
  - If `line_y` < `LINES`-1, fetch line `line_y`+1 into half `(line_y+1)[0]`. Otherwise no fetch.
- **Fetch address** = `disp_base` + y·40 + w. Compute y·40 as (y<<5)+(y<<3), zero-extended to 22 bits. w runs 0..39.
- **States:** IDLE, REQ, WAIT_DATA, PAUSE, DRAIN.
  - IDLE: on a fetch event, go to PAUSE if `sdram_wait`, else REQ.
  - REQ: `sdram_rd`=1 with `sdram_addr` held stable. When `sdram_ac`=1, drop `sdram_rd` next cycle and go to WAIT_DATA.
  - WAIT_DATA: on `sdram_rdvalid`, write the word to line buffer [half][w].
    - If w=39: go to IDLE.
    - Otherwise w+1, then PAUSE if `sdram_wait`, else REQ.
  - PAUSE: go to REQ when `sdram_wait`=0.
  - DRAIN: wait for the outstanding `sdram_rdvalid` and discard the word, then start the pending fetch.
- **Fetch event while `busy`** (line or frame):
  - Set `underrun`.
  - From REQ or PAUSE: restart immediately at the new line, w=0.
  - From WAIT_DATA: go to DRAIN.
- **Simultaneous `new_frame` and `line_start`:** `new_frame` wins.
- `frame_flip` changes are ignored except at `new_frame`.
- `busy` = state ≠ IDLE.
- **Pixel read:**
  - Word = `draw_x[9:4]`, byte = `draw_x[3:0]` of the display half.
  - `draw_x` ≥ 640 returns 8'h00.

## Timing
- **Reset values:**
  - Outputs: `sdram_rd`=0, `sdram_addr`=0, `pixel`=0, `busy`=0, `underrun`=0.
  - Internal: state IDLE, `disp_base`=`FB_BASE1`, display half 0.
- **Pixel latency:** 2 cycles (registered RAM read plus registered byte mux). `pixel` at cycle t+2 corresponds to `draw_x` at t.
- **Request handshake:**
  - `sdram_rd` asserts the cycle after entering REQ.
  - The address must not change while `sdram_rd`=1.
  - At most one read is outstanding.
- **Fetch timing:** a line fetch takes ≥ 40·(2+L) cycles for read latency L. It must complete within one line period.
- **Mid-operation reset:** returns to the reset values immediately. Any in-flight `sdram_rdvalid` after reset is ignored.

## Structure
- Shared package `fb_pkg`:
  - `FB_BASE0` / `FB_BASE1`, `WORDS_PER_LINE`, `LINES`.
  - The state enum.
  - A `line_addr(base,y)` function, shared with the blitters.
- One sub-module, `scan_line_buf`: a 2×40×128 simple dual-port RAM.
  - Write port: fetch FSM.
  - Read port: pixel path, 1-cycle registered read.

## Test plan
- **Reset then frame:** reset, `frame_flip`=0, `new_frame` -> 40 reads at 0x200000..0x200027 in order; `busy` falls after the 40th `sdram_rdvalid`.
- **Line fetch and pixel:** `line_start`, `line_y`=5, `frame_flip`=1 at frame -> reads start at 0x100000+240. Then, displaying line 6, `draw_x`=17 -> `pixel` = byte 1 of word 1, two cycles later.
- **Back-pressure:** hold `sdram_wait`=1 for 10 cycles mid-line -> `sdram_rd` stays 0, no word skipped or duplicated, 40 writes total. Delay `sdram_ac` 5 cycles -> `sdram_addr` stays stable.
- **Last line:** `line_start` with `line_y`=479 -> no request issued; `busy` stays 0.
- **Underrun:** `line_start` during WAIT_DATA -> DRAIN, stale word discarded, `underrun`=1, new fetch starts at w=0.
- **Async reset:** reset asserted mid-fetch -> `sdram_rd`=0 and `busy`=0 immediately; a following `new_frame` fetches normally.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, scanout fetch states and the line address helper
// shared by scanout and the blitters.
package fb_pkg;
  localparam logic [21:0] FB_BASE0 = 22'h100000;
  localparam logic [21:0] FB_BASE1 = 22'h200000;
  localparam int WORDS_PER_LINE = 40;
  localparam int LINES = 480;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, PAUSE, DRAIN} scan_state_t;
  function automatic logic [21:0] line_addr(input logic [21:0] base, input logic [9:0] y);
    logic [21:0] w_y;
    w_y = {12'd0, y};
    return base + (w_y << 5) + (w_y << 3);
  endfunction
endpackage

// File: rtl/scan_line_buf.sv
// scan_line_buf: ping-pong line buffer, two halves of one line of 128-bit words,
// one write port and one registered read port.
module scan_line_buf (
  input  logic         clk,
  input  logic         i_we,
  input  logic         i_wr_half,
  input  logic [5:0]   i_wr_word,
  input  logic [127:0] i_wr_data,
  input  logic         i_rd_half,
  input  logic [5:0]   i_rd_word,
  output logic [127:0] o_rd_data
);
  import fb_pkg::*;
  logic [127:0] r_mem [2][WORDS_PER_LINE];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_half][i_wr_word] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_half][i_rd_word];
  end
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: fetches the off-screen framebuffer one line ahead into a
// ping-pong line buffer and returns the palette index for draw_x.
module framebuffer_scanout #(
  parameter logic [21:0] FB_BASE0       = fb_pkg::FB_BASE0,
  parameter logic [21:0] FB_BASE1       = fb_pkg::FB_BASE1,
  parameter int          WORDS_PER_LINE = fb_pkg::WORDS_PER_LINE,
  parameter int          LINES          = fb_pkg::LINES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_flip,
  input  logic         new_frame,
  input  logic         line_start,
  input  logic [9:0]   line_y,
  input  logic [9:0]   draw_x,
  input  logic         sdram_wait,
  input  logic         sdram_ac,
  input  logic         sdram_rdvalid,
  input  logic [127:0] sdram_rdata,
  output logic         sdram_rd,
  output logic [21:0]  sdram_addr,
  output logic [7:0]   pixel,
  output logic         busy,
  output logic         underrun
);
  import fb_pkg::*;
  scan_state_t r_state, w_state_n, w_go;
  logic [21:0] r_base, w_base_n, r_addr;
  logic [9:0] r_y, w_y_n;
  logic [5:0] r_w, w_w_n;
  logic r_half, w_half_n, r_disp_half, r_underrun, r_vld;
  logic [3:0] r_sel;
  logic [7:0] r_pixel;
  logic [127:0] w_rd_word;
  logic w_line_ev, w_ev, w_last, w_wr, w_x_ok;
  assign w_line_ev = line_start && (line_y < 10'(LINES - 1));
  assign w_ev = new_frame || w_line_ev;
  assign w_last = r_w == 6'(WORDS_PER_LINE - 1);
  assign w_go = sdram_wait ? PAUSE : REQ;
  // a word landing in the same cycle as a new fetch event belongs to the abandoned line
  assign w_wr = (r_state == WAIT_DATA) && sdram_rdvalid && !w_ev;
  assign w_x_ok = draw_x < 10'd640;
  assign sdram_rd = r_state == REQ;
  assign sdram_addr = r_addr;
  assign busy = r_state != IDLE;
  assign underrun = r_underrun;
  assign pixel = r_pixel;
  always_comb begin
    w_base_n = new_frame ? (frame_flip ? FB_BASE0 : FB_BASE1) : r_base;
    w_y_n = new_frame ? 10'd0 : w_line_ev ? line_y + 10'd1 : r_y;
    w_half_n = new_frame ? 1'b0 : w_line_ev ? ~line_y[0] : r_half;
    w_w_n = w_ev ? 6'd0 : (w_wr && !w_last) ? r_w + 6'd1 : r_w;
    w_state_n = r_state;
    case (r_state)
      IDLE:      w_state_n = w_ev ? w_go : IDLE;
      REQ:       w_state_n = sdram_ac ? (w_ev ? DRAIN : WAIT_DATA) : (w_ev ? w_go : REQ);
      WAIT_DATA: w_state_n = w_ev ? (sdram_rdvalid ? w_go : DRAIN) :
                             !sdram_rdvalid ? WAIT_DATA : w_last ? IDLE : w_go;
      PAUSE:     w_state_n = w_go;
      DRAIN:     w_state_n = sdram_rdvalid ? w_go : DRAIN;
      default:   w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_base <= FB_BASE1;
      r_y <= '0;
      r_w <= '0;
      r_half <= 1'b0;
      r_disp_half <= 1'b0;
      r_addr <= '0;
      r_underrun <= 1'b0;
      r_sel <= '0;
      r_vld <= 1'b0;
      r_pixel <= '0;
    end else begin
      r_state <= w_state_n;
      r_base <= w_base_n;
      r_y <= w_y_n;
      r_w <= w_w_n;
      r_half <= w_half_n;
      if (w_state_n == REQ || w_state_n == PAUSE) r_addr <= line_addr(w_base_n, w_y_n) + 22'(w_w_n);
      if (w_ev && r_state != IDLE) r_underrun <= 1'b1;
      if (line_start && !new_frame) r_disp_half <= line_y[0];
      r_sel <= draw_x[3:0];
      r_vld <= w_x_ok;
      r_pixel <= r_vld ? w_rd_word[{r_sel, 3'b000} +: 8] : 8'h00;
    end
  end
  scan_line_buf u_buf (
    .clk(clk),
    .i_we(w_wr),
    .i_wr_half(r_half),
    .i_wr_word(r_w),
    .i_wr_data(sdram_rdata),
    .i_rd_half(r_disp_half),
    .i_rd_word(w_x_ok ? draw_x[9:4] : 6'd0),
    .o_rd_data(w_rd_word)
  );
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed bench with a small SDRAM responder; pixel data
// byte k of the word at address a is a[7:0]+k.
module tb_framebuffer_scanout;
  logic clk = 1'b0, reset = 1'b1, frame_flip = 1'b0, new_frame = 1'b0, line_start = 1'b0;
  logic [9:0] line_y = '0, draw_x = '0;
  logic sdram_wait = 1'b0, sdram_ac = 1'b0, sdram_rdvalid = 1'b0;
  logic [127:0] sdram_rdata = '0;
  logic sdram_rd, busy, underrun;
  logic [21:0] sdram_addr;
  logic [7:0] pixel;
  int checks = 0, failures = 0;
  int lat = 2, ac_delay = 0, wait_after = -1;
  int ac_cnt = 0, rv_cnt = 0, wait_left = 0, ac_wait = 0, pend_left = 0, rd_in_wait = 0, addr_moves = 0;
  logic [21:0] pend_addr = '0, prev_addr = '0;
  logic prev_rd = 1'b0;
  logic [21:0] acc_q[$];

  framebuffer_scanout dut (
    .clk(clk), .reset(reset), .frame_flip(frame_flip), .new_frame(new_frame),
    .line_start(line_start), .line_y(line_y), .draw_x(draw_x),
    .sdram_wait(sdram_wait), .sdram_ac(sdram_ac), .sdram_rdvalid(sdram_rdvalid),
    .sdram_rdata(sdram_rdata), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
    .pixel(pixel), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input logic [21:0] a);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = a[7:0] + 8'(k);
    return v;
  endfunction

  // SDRAM responder: one read outstanding, optional accept delay and wait burst
  initial forever begin
    @(negedge clk);
    sdram_ac = 1'b0;
    sdram_rdvalid = 1'b0;
    if (sdram_rd && prev_rd && sdram_addr != prev_addr) addr_moves++;
    prev_rd = sdram_rd;
    prev_addr = sdram_addr;
    if (wait_left > 0) begin
      if (sdram_rd) rd_in_wait++;
      wait_left--;
      sdram_wait = wait_left > 0;
    end
    if (pend_left > 0) begin
      pend_left--;
      if (pend_left == 0) begin
        sdram_rdvalid = 1'b1;
        sdram_rdata = word_of(pend_addr);
        rv_cnt++;
      end
    end else if (sdram_rd && !sdram_wait) begin
      if (ac_wait < ac_delay) ac_wait++;
      else begin
        ac_wait = 0;
        sdram_ac = 1'b1;
        ac_cnt++;
        acc_q.push_back(sdram_addr);
        pend_addr = sdram_addr;
        pend_left = lat;
        if (ac_cnt == wait_after) begin
          sdram_wait = 1'b1;
          wait_left = 10;
        end
      end
    end else ac_wait = 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_frame(input logic flip);
    @(negedge clk);
    frame_flip = flip;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  task automatic pulse_line(input logic [9:0] y);
    @(negedge clk);
    line_y = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_fetch(input string tag, input int s, input logic [21:0] base);
    int bad = 0;
    for (int i = 0; i < 40; i++) if (s + i >= acc_q.size() || acc_q[s+i] !== base + 22'(i)) bad++;
    check({tag, "_count"}, 32'(acc_q.size() - s), 32'd40);
    check({tag, "_seq"}, 32'(bad), 32'd0);
  endtask

  task automatic check_pix(input string tag, input logic [9:0] x, input logic [7:0] exp);
    @(negedge clk);
    draw_x = x;
    repeat (2) @(negedge clk);
    check(tag, 32'(pixel), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, rv0, c0, n, hits;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(sdram_rd), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    // reset base is FB_BASE1: line 1 lives at 0x200028
    s = acc_q.size();
    pulse_line(10'd0);
    wait_idle("rst_base");
    check_fetch("rst_base", s, 22'h200028);
    // frame_flip=0 -> scan FB_BASE1
    s = acc_q.size();
    rv0 = rv_cnt;
    pulse_frame(1'b0);
    wait_idle("frame0");
    check_fetch("frame0", s, 22'h200000);
    check("frame0_rdvalid", 32'(rv_cnt - rv0), 32'd40);
    // frame_flip=1 -> scan FB_BASE0, line 6 at 0x1000F0
    s = acc_q.size();
    pulse_frame(1'b1);
    wait_idle("frame1");
    check_fetch("frame1", s, 22'h100000);
    s = acc_q.size();
    pulse_line(10'd5);
    wait_idle("line6");
    check_fetch("line6", s, 22'h1000F0);
    pulse_line(10'd6);
    @(negedge clk);
    draw_x = 10'd0;
    @(negedge clk);
    draw_x = 10'd17;
    @(negedge clk);
    check("pix_x0", 32'(pixel), 32'h0F0);
    @(negedge clk);
    check("pix_x17", 32'(pixel), 32'h0F2);
    check_pix("pix_x639", 10'd639, 8'h26);
    check_pix("pix_x640", 10'd640, 8'h00);
    wait_idle("line7");
    check("no_underrun", 32'(underrun), 32'd0);
    // back-pressure: 5-cycle accept delay plus a 10-cycle wait burst mid-line
    ac_delay = 5;
    wait_after = ac_cnt + 5;
    s = acc_q.size();
    rv0 = rv_cnt;
    pulse_line(10'd9);
    wait_idle("bp");
    check_fetch("bp", s, 22'h100190);
    check("bp_rdvalid", 32'(rv_cnt - rv0), 32'd40);
    check("bp_rd_in_wait", 32'(rd_in_wait), 32'd0);
    check("bp_addr_stable", 32'(addr_moves), 32'd0);
    ac_delay = 0;
    pulse_line(10'd478);
    check_pix("bp_pix_w20", 10'd323, 8'hA7);
    check_pix("bp_pix_w39", 10'd639, 8'hC6);
    wait_idle("line479");
    // last line: no fetch
    s = acc_q.size();
    pulse_line(10'd479);
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || sdram_rd) hits++;
    end
    check("last_idle", 32'(hits), 32'd0);
    check("last_no_req", 32'(acc_q.size() - s), 32'd0);
    check("last_underrun", 32'(underrun), 32'd0);
    // underrun: new line event while waiting for data
    lat = 3;
    c0 = ac_cnt;
    pulse_line(10'd20);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ac_cnt >= c0 + 3 && pend_left > 0 && !sdram_rd) && n < 2000);
    check("ur_reach_wait", 32'(n < 2000), 32'd1);
    s = acc_q.size();
    pulse_line(10'd30);
    check("ur_flag", 32'(underrun), 32'd1);
    check("ur_busy", 32'(busy), 32'd1);
    wait_idle("ur");
    check_fetch("ur", s, 22'h1004D8);
    pulse_line(10'd31);
    check_pix("ur_pix_w0", 10'd0, 8'hD8);
    check_pix("ur_pix_w1", 10'd20, 8'hDD);
    wait_idle("line32");
    // async reset mid-fetch, then a clean frame
    lat = 2;
    c0 = ac_cnt;
    pulse_frame(1'b0);
    n = 0;
    while (ac_cnt < c0 + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_rd", 32'(sdram_rd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(sdram_addr), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_idle", 32'(busy), 32'd0);
    s = acc_q.size();
    pulse_frame(1'b0);
    wait_idle("arst_frame");
    check_fetch("arst_frame", s, 22'h200000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
